slideshow_ctrl: RTL and testbench
=================================

SLIDESHOW_CTRL -- requirements
Module: slideshow_ctrl

Interface
REQ-001 The block SHALL have parameter N_IMG, default 4, number of image sources (2..16).
REQ-002 The block SHALL have parameter IMG_W, default 160, image width in source pixels.
REQ-003 The block SHALL have parameter IMG_H, default 120, image height in source pixels.
REQ-004 The block SHALL have parameter SCALE_LOG2, default 2, log2 of the screen-pixels-per-source-pixel upscale factor.
REQ-005 The block SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles (1..4).
REQ-006 The block SHALL have parameter DWELL_FRAMES, default 60, frames each image is shown in auto mode (>=1).
REQ-007 The block SHALL have the following ports:
- clk_i  in  1  pixel clock; the single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- sel_i  in  N_IMG  one-hot image select request.
- auto_i  in  1  1 = auto-advance mode, 0 = manual.
- hsync_i, vsync_i  in  1 each  timer syncs, active-low.
- visible_i  in  1  timer active-video flag.
- pos_x_i, pos_y_i  in  10 each  timer pixel coordinates.
- rom_addr_o  out  $clog2(IMG_W*IMG_H)  shared ROM address.
- img_rdata_i  in  12*N_IMG  RGB444 data; image k at bits [12k+11:12k].
- vga_red_o, vga_green_o, vga_blue_o  out  4 each  colour.
- vga_hsync_o, vga_vsync_o  out  1 each  syncs aligned to colour.
- cur_img_o  out  $clog2(N_IMG)  index of the image currently displayed.

Function
REQ-008 sx = pos_x_i>>SCALE_LOG2 and sy = pos_y_i>>SCALE_LOG2.
REQ-009 rom_addr_o SHALL be combinational: sy*IMG_W+sx when sx<IMG_W and sy<IMG_H, else 0.
REQ-010 hsync_i, vsync_i, visible_i and an in-image flag SHALL be delayed through exactly ROM_LAT register stages.
REQ-011 The colour outputs SHALL be combinational from the delayed flags: the active image's 12-bit word when delayed visible and in-image are both 1, else 0.
REQ-012 vga_hsync_o and vga_vsync_o SHALL be the ROM_LAT-delayed syncs.
REQ-013 A frame boundary SHALL be the cycle in which vsync_i is 0 and its previous registered value is 1.
REQ-014 sel_i SHALL be valid only when exactly one bit is set.
- Valid: loads pending_q with that bit's index.
- Zero or multi-hot: ignored, pending_q holds.
REQ-015 The active image SHALL change only at a frame boundary, never mid-frame.
REQ-016 The FSM SHALL have two states, MANUAL and AUTO. Its state register updates every cycle from auto_i: 1 selects AUTO, 0 selects MANUAL.
REQ-017 In MANUAL, at each frame boundary, active_q <= pending_q.
REQ-018 In AUTO, the dwell counter SHALL increment at each frame boundary.
- Counter width: $clog2(DWELL_FRAMES+1).
- At a boundary where it equals DWELL_FRAMES-1: active_q <= (active_q+1) mod N_IMG, counter <= 0, pending_q <= new active_q.
REQ-019 In AUTO, a valid sel_i SHALL clear the dwell counter and set a pending-override flag. At the next boundary: active_q <= pending_q, override flag cleared, counter restarts from 0.
REQ-020 A valid sel_i in the same cycle as a frame boundary SHALL take effect at that boundary. Priority: sel_i, then override, then auto-advance.
REQ-021 On an AUTO->MANUAL transition, pending_q <= active_q and the dwell counter <= 0, so the displayed image does not change.
REQ-022 cur_img_o SHALL equal active_q.

Reset
REQ-023 While rst_i is high, regardless of clock:
- active_q, pending_q, dwell counter, override flag <= 0; FSM <= MANUAL.
- Delayed visible and in-image flags <= 0; delayed syncs and previous-vsync register <= 1.
- Hence colour outputs = 0, vga_hsync_o = vga_vsync_o = 1, rom_addr_o per REQ-009.
REQ-024 Reset asserted mid-frame SHALL abandon any pending selection. After release, image 0 displays from the next frame boundary.

Verification
REQ-025 Manual select: sel_i=4'b0100 pulsed mid-frame -> cur_img_o stays 0 until the next vsync falling edge, then becomes 2; colour equals image2 data from the next visible pixel.
REQ-026 Invalid select: sel_i=4'b0110 or 4'b0000 -> pending_q and cur_img_o unchanged across 3 frames.
REQ-027 Auto advance with DWELL_FRAMES=3, N_IMG=4 -> cur_img_o steps 0,1,2,3,0 every 3 frame boundaries.
REQ-028 Override in auto: sel_i=4'b1000 during frame 1 of a dwell -> image 3 shown at the next boundary, then advances to 0 exactly 3 boundaries later.
REQ-029 Latency with ROM_LAT=2: pos=(4,0) with visible -> rom_addr_o=1; colour and syncs appear 2 cycles later. pos=(640,...) or sy>=120 -> colour 0.
REQ-030 Reset mid-frame while image 2 is active -> all outputs at reset values immediately (asynchronous); after release, cur_img_o=0.

Source files
------------

// File: rtl/slideshow_ctrl.sv
// slideshow_ctrl: upscaled multi-image ROM slideshow with manual/auto frame-synchronous image switching
module slideshow_ctrl #(
    parameter int N_IMG = 4,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int ROM_LAT = 1,
    parameter int DWELL_FRAMES = 60,
    localparam int AW = $clog2(IMG_W*IMG_H),
    localparam int IW = $clog2(N_IMG),
    localparam int CW = $clog2(DWELL_FRAMES+1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_IMG-1:0]  sel_i,
    input  logic              auto_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              visible_i,
    input  logic [9:0]        pos_x_i,
    input  logic [9:0]        pos_y_i,
    output logic [AW-1:0]     rom_addr_o,
    input  logic [12*N_IMG-1:0] img_rdata_i,
    output logic [3:0]        vga_red_o,
    output logic [3:0]        vga_green_o,
    output logic [3:0]        vga_blue_o,
    output logic              vga_hsync_o,
    output logic              vga_vsync_o,
    output logic [IW-1:0]     cur_img_o
);
    typedef enum logic {MANUAL, AUTO} state_t;
    state_t state_q, state_d;
    logic [9:0] sx, sy;
    logic in_img, fb, sel_ok, last, vs_prev_q;
    logic [IW-1:0] sel_idx, nxt, active_q, active_d, pending_q, pending_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic ovr_q, ovr_d;
    logic [3:0] pipe [ROM_LAT];
    logic [3:0] tail;
    assign sx = pos_x_i >> SCALE_LOG2;
    assign sy = pos_y_i >> SCALE_LOG2;
    assign in_img = (32'(sx) < IMG_W) && (32'(sy) < IMG_H);
    assign rom_addr_o = in_img ? AW'(32'(sy)*IMG_W + 32'(sx)) : '0;
    // flag pipeline per stage: {hsync, vsync, visible, in_img}
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= 4'b1100;
        end else begin
            pipe[0] <= {hsync_i, vsync_i, visible_i, in_img};
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign tail = pipe[ROM_LAT-1];
    assign {vga_red_o, vga_green_o, vga_blue_o} = (tail[1] && tail[0]) ? img_rdata_i[12*32'(active_q) +: 12] : 12'h000;
    assign vga_hsync_o = tail[3];
    assign vga_vsync_o = tail[2];
    assign cur_img_o = active_q;
    assign fb = !vsync_i && vs_prev_q;
    assign sel_ok = $onehot(sel_i);
    assign last = dwell_q == CW'(DWELL_FRAMES-1);
    assign nxt = (active_q == IW'(N_IMG-1)) ? '0 : active_q + 1'b1;
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_IMG; i++) if (sel_i[i]) sel_idx = IW'(i);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MANUAL;
            active_q <= '0;
            pending_q <= '0;
            dwell_q <= '0;
            ovr_q <= 1'b0;
            vs_prev_q <= 1'b1;
        end else begin
            state_q <= state_d;
            active_q <= active_d;
            pending_q <= pending_d;
            dwell_q <= dwell_d;
            ovr_q <= ovr_d;
            vs_prev_q <= vsync_i;
        end
    end
    always_comb begin
        state_d = auto_i ? AUTO : MANUAL;
        active_d = active_q;
        pending_d = sel_ok ? sel_idx : pending_q;
        dwell_d = dwell_q;
        ovr_d = ovr_q;
        if (state_q == MANUAL) begin
            dwell_d = '0;
            ovr_d = 1'b0;
            active_d = fb ? pending_d : active_q;
        end else if (fb) begin
            dwell_d = (sel_ok || ovr_q || last) ? '0 : dwell_q + 1'b1;
            ovr_d = 1'b0;
            active_d = sel_ok ? sel_idx : ovr_q ? pending_q : last ? nxt : active_q;
            pending_d = (!sel_ok && !ovr_q && last) ? nxt : pending_d;
        end else if (sel_ok) begin
            dwell_d = '0;
            ovr_d = 1'b1;
        end
        // leaving auto freezes the shown image as the manual choice
        if (state_q == AUTO && !auto_i) begin
            pending_d = active_d;
            dwell_d = '0;
            ovr_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_slideshow_ctrl.sv
// tb_slideshow_ctrl: scoreboard bench for slideshow_ctrl with ROM_LAT=2, DWELL_FRAMES=3, N_IMG=4
module tb_slideshow_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] sel;
    logic auto_m, hsync, vsync, visible;
    logic [9:0] pos_x, pos_y;
    logic [14:0] rom_addr, a1, a2;
    logic [47:0] img_rdata;
    logic [3:0] red, green, blue;
    logic vga_hs, vga_vs;
    logic [1:0] cur;
    int checks = 0;
    int errors = 0;
    int exp_img = 0;
    logic [13:0] q [$];

    always #5 clk = ~clk;

    slideshow_ctrl #(.N_IMG(4), .ROM_LAT(2), .DWELL_FRAMES(3)) dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .auto_i(auto_m),
        .hsync_i(hsync), .vsync_i(vsync), .visible_i(visible),
        .pos_x_i(pos_x), .pos_y_i(pos_y), .rom_addr_o(rom_addr),
        .img_rdata_i(img_rdata), .vga_red_o(red), .vga_green_o(green),
        .vga_blue_o(blue), .vga_hsync_o(vga_hs), .vga_vsync_o(vga_vs),
        .cur_img_o(cur)
    );

    // two-cycle ROM model: image k returns {k, addr[7:0]}
    always @(posedge clk) begin
        a1 <= rom_addr;
        a2 <= a1;
    end
    always_comb begin
        img_rdata = '0;
        for (int k = 0; k < 4; k++) img_rdata[12*k +: 12] = {4'(k), a2[7:0]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) q.delete();
        else if (q.size() > 2) check("pix", 32'({vga_hs, vga_vs, red, green, blue}), 32'(q.pop_front()));
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic vis, input logic hs, input logic vs, input logic [3:0] s);
        logic [9:0] px, py;
        logic inimg;
        logic [14:0] ea;
        @(posedge clk);
        #1;
        pos_x = x; pos_y = y; visible = vis; hsync = hs; vsync = vs; sel = s;
        px = x >> 2;
        py = y >> 2;
        inimg = (px < 160) && (py < 120);
        ea = inimg ? 15'(py*160 + px) : 15'd0;
        q.push_back({hs, vs, (vis && inimg) ? {4'(exp_img), ea[7:0]} : 12'h000});
        #1 check("addr", 32'(rom_addr), 32'(ea));
    endtask

    task automatic frame(input logic [3:0] s, input logic [3:0] b, input logic drop);
        pix(0, 0, 1, 1, 1, 0);
        pix(4, 0, 1, 1, 1, 0);
        pix(13, 7, 1, 1, 1, s);
        pix(636, 476, 1, 1, 1, 0);
        check("hold", 32'(cur), 32'(exp_img));
        if (drop) auto_m = 1'b0;
        pix(640, 0, 1, 1, 1, 0);
        pix(0, 480, 1, 1, 1, 0);
        pix(8, 8, 0, 0, 1, 0);
        pix(0, 0, 0, 1, 0, b);
        pix(0, 0, 0, 1, 0, 0);
        repeat (3) pix(0, 0, 0, 1, 1, 0);
    endtask

    task automatic next(input string tag, input int img);
        exp_img = img;
        check(tag, 32'(cur), 32'(img));
    endtask

    initial begin
        rst = 1'b1; sel = '0; auto_m = 1'b0; hsync = 1'b1; vsync = 1'b1;
        visible = 1'b0; pos_x = 10'd4; pos_y = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rgb", 32'({red, green, blue}), 32'h0);
        check("rst_sync", 32'({vga_hs, vga_vs}), 32'h3);
        check("rst_cur", 32'(cur), 32'h0);
        check("rst_addr", 32'(rom_addr), 32'h1);
        @(negedge clk) rst = 1'b0;
        frame(0, 0, 0);            next("idle", 0);
        frame(4'b0100, 0, 0);      next("man_sel", 2);
        frame(4'b0110, 0, 0);      next("multi", 2);
        frame(4'b0000, 0, 0);      next("zero", 2);
        frame(4'b0000, 0, 0);      next("inv3", 2);
        frame(4'b0001, 0, 0);      next("man_0", 0);
        auto_m = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            frame(0, 0, 0);
            next("auto", (i / 3) % 4);
        end
        frame(0, 0, 0);            next("dw1", 0);
        frame(4'b1000, 0, 0);      next("ovr", 3);
        frame(0, 0, 0);            next("ovr_b1", 3);
        frame(0, 0, 0);            next("ovr_b2", 3);
        frame(0, 0, 0);            next("ovr_b3", 0);
        frame(0, 4'b0010, 0);      next("bsel", 1);
        frame(0, 0, 0);            next("bsel_b1", 1);
        frame(0, 0, 0);            next("bsel_b2", 1);
        frame(0, 0, 0);            next("bsel_b3", 2);
        frame(4'b0001, 0, 1);      next("to_man", 2);
        frame(0, 0, 0);            next("man_keep", 2);
        repeat (4) pix(4, 0, 1, 1, 1, 0);
        @(negedge clk);
        check("pre_rst_red", 32'(red), 32'h2);
        pix(4, 0, 1, 1, 1, 4'b1000);
        #2 rst = 1'b1;
        q.delete();
        #1;
        check("arst_rgb", 32'({red, green, blue}), 32'h0);
        check("arst_sync", 32'({vga_hs, vga_vs}), 32'h3);
        check("arst_cur", 32'(cur), 32'h0);
        check("arst_addr", 32'(rom_addr), 32'h1);
        sel = '0;
        exp_img = 0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        frame(0, 0, 0);            next("post_rst", 0);
        frame(4'b0100, 0, 0);      next("post_sel", 2);
        repeat (4) pix(0, 0, 0, 1, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
